cdb_broadcast: RTL and testbench
================================

Name: cdb_broadcast

Overview:
- Producer side of the completion interface. Collects finished results from NUM_FU functional units and selects up to N per cycle with rotating priority.
- Drives the N-wide common data bus. Each lane carries a physical-register tag, ROB index and value.
- The tags feed the complete-bit tracker, the reservation-station wakeup and the ROB complete marking.
- Sits between the execute stage and all completion consumers. Provides one result buffer per functional unit plus a ready backpressure signal.

Parameters:
- N, `N, broadcast lanes per cycle (superscalar width).
- NUM_FU, 4, number of functional-unit result ports.
- PHYS_REG_SZ, `PHYS_REG_SZ_R10K, physical register count; this value is also the "no destination" sentinel tag.
- TAG_BITS, `PHYS_REG_ID_BITS+1, tag width (big index, able to hold the sentinel).
- ROB_BITS, `ROB_IDX_BITS, ROB index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  mispredict flush; discards all buffered and outgoing results.
- fu_valid  in  NUM_FU  FU i presents a finished result this cycle.
- fu_tag  in  NUM_FU x TAG_BITS  destination physical register, or PHYS_REG_SZ if none.
- fu_rob_idx  in  NUM_FU x ROB_BITS  ROB entry of the result.
- fu_value  in  NUM_FU x 32  result data.
- fu_ready  out  NUM_FU  buffer i accepts a result at this clock edge.
- cdb_valid  out  N  lane j carries a completion.
- cdb_tag  out  N x TAG_BITS  broadcast tag; PHYS_REG_SZ when the lane is invalid.
- cdb_rob_idx  out  N x ROB_BITS  ROB index of the broadcast.
- cdb_value  out  N x 32  broadcast data.

Behaviour:
- State:
  - per FU: buf_valid plus a {tag, rob_idx, value} entry;
  - rr_ptr (clog2(NUM_FU) bits);
  - registered cdb_* outputs.
- Reset, synchronous:
  - buf_valid all 0; rr_ptr 0;
  - cdb_valid all 0; cdb_tag all PHYS_REG_SZ; cdb_rob_idx and cdb_value all 0.
  - Reset overrides squash and all inputs.
- Selection, combinational from state only:
  - Scan buffers in the order rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - Grant the first min(N, occupied) buffers with buf_valid=1.
  - Lane assignment follows scan order: first grant goes to lane 0.
- fu_ready[i] = ~buf_valid[i] | grant[i]. It has no combinational dependence on fu_valid.
- Clock edge, no squash:
  - Granted entries load the cdb lanes and become visible the next cycle, so broadcast latency is 1 cycle after buffering.
  - Ungranted lanes load valid=0 and tag=PHYS_REG_SZ.
  - A granted buffer clears, unless fu_valid[i] is high in the same cycle. In that case the new result is written, and drain and refill happen in the same cycle.
  - An ungranted, empty buffer with fu_valid=1 captures the result.
  - An ungranted, full buffer ignores fu_valid. The FU must hold until it sees ready.
  - Minimum FU-to-bus latency is 2 cycles: capture, then broadcast.
- rr_ptr:
  - If at least one grant, rr_ptr = (index of last granted FU + 1) mod NUM_FU.
  - Otherwise unchanged.
  - Guarantees no FU waits more than ceil(NUM_FU/N) selection cycles.
- Squash:
  - At the edge, clear every buf_valid, drive all cdb lanes invalid with sentinel tag, and reset rr_ptr to 0.
  - Results offered by FUs in the squash cycle are dropped, even though fu_ready may be high.
- Sentinel-tag results, fu_valid=1 with tag PHYS_REG_SZ: buffered and broadcast normally with cdb_valid=1, because the ROB needs them. Consumers ignore the tag.
- Duplicate tags across lanes in one cycle are not checked; the issue logic guarantees uniqueness.

Decomposition:
- Shared package:
  - CDB_PACKET struct {valid, tag, rob_idx, value};
  - PHYS_REG_IDX_BIG typedef;
  - sentinel constant NO_PREG = PHYS_REG_SZ_R10K.
- Sub-module rr_select: parameterised NUM_FU/N rotating-priority N-grant selector. Outputs a grant vector and per-lane one-hot source indices. Reused later by issue select.

Test Plan (N=2, NUM_FU=4):
- Reset, then idle 3 cycles:
  - cdb_valid=00, cdb_tag=PHYS_REG_SZ on both lanes, fu_ready=1111.
- Single result: FU1 valid tag 5, rob 3, value 0xDEAD at cycle 0:
  - cycle 2 lane0 valid tag 5 / rob 3 / 0xDEAD, lane1 invalid;
  - rr_ptr becomes 2.
- All four FUs valid at cycle 0 with tags 10–13, held until ready:
  - cycle 2 broadcasts tags 10 and 11 and fu_ready shows 0011;
  - cycle 3 broadcasts tags 12 and 13;
  - no tag lost or duplicated.
- Continuous pressure: FU0 presents every cycle, FU3 holds one result:
  - FU3's tag appears within 2 broadcast cycles, so there is no starvation.
- Squash while 3 buffers are full and lanes are valid:
  - next cycle cdb_valid=00 and fu_ready=1111;
  - prior tags never appear.
- Drain-and-refill: FU2 full and granted while fu_valid[2]=1 with tag 7:
  - old tag broadcast next cycle;
  - tag 7 broadcast within the following selection cycles.
- Sentinel: FU0 valid with tag PHYS_REG_SZ:
  - cdb_valid=1 with cdb_tag=PHYS_REG_SZ.

Source files
------------

// File: rtl/cdb_broadcast_pkg.sv
// Shared types and constants for the completion (common data bus) path.
// Holds the default machine widths, the big physical-register index type
// (wide enough for the "no destination" sentinel) and the CDB lane payload.
package cdb_broadcast_pkg;

    localparam int unsigned CDB_LANES        = 2;
    localparam int unsigned CDB_NUM_FU       = 4;
    localparam int unsigned PHYS_REG_SZ_R10K = 64;
    localparam int unsigned PHYS_REG_ID_BITS = 6;
    localparam int unsigned ROB_IDX_BITS     = 5;
    localparam int unsigned CDB_TAG_BITS     = PHYS_REG_ID_BITS + 1;
    localparam int unsigned CDB_DATA_BITS    = 32;

    // Physical register index with one extra bit so the sentinel fits.
    typedef logic [CDB_TAG_BITS-1:0] PHYS_REG_IDX_BIG;

    // Tag meaning "this result writes no physical register".
    localparam PHYS_REG_IDX_BIG NO_PREG = CDB_TAG_BITS'(PHYS_REG_SZ_R10K);

    // One completion as carried on a bus lane or held in a result buffer.
    typedef struct packed {
        logic                     valid;
        PHYS_REG_IDX_BIG          tag;
        logic [ROB_IDX_BITS-1:0]  rob_idx;
        logic [CDB_DATA_BITS-1:0] value;
    } CDB_PACKET;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority N-of-NUM_FU grant selector.
// Scans requesters starting at ptr_i and wrapping, granting the first N
// that request. Lane j receives the j-th grant in scan order.
// Ports:
//   req_i        - request vector, one bit per source
//   ptr_i        - scan start position
//   grant_c      - sources granted this cycle
//   lane_valid_c - lane j holds a grant
//   lane_src_c   - one-hot source index per lane
//   next_ptr_c   - one past the last granted source, or ptr_i if none
module rr_select #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned N      = 2,
    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0]        req_i,
    input  logic [PTR_W-1:0]         ptr_i,
    output logic [NUM_FU-1:0]        grant_c,
    output logic [N-1:0]             lane_valid_c,
    output logic [N-1:0][NUM_FU-1:0] lane_src_c,
    output logic [PTR_W-1:0]         next_ptr_c
);

    // Wrapped scan; cnt tracks how many lanes are already filled.
    always_comb begin
        int unsigned      cnt;
        logic [PTR_W-1:0] idx;
        grant_c      = '0;
        lane_valid_c = '0;
        lane_src_c   = '0;
        next_ptr_c   = ptr_i;
        cnt          = 0;
        idx          = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = PTR_W'((32'(ptr_i) + k) % NUM_FU);
            if (req_i[idx] && (cnt < N)) begin
                grant_c[idx] = 1'b1;
                for (int unsigned j = 0; j < N; j++) begin
                    if (j == cnt) begin
                        lane_valid_c[j]    = 1'b1;
                        lane_src_c[j][idx] = 1'b1;
                    end
                end
                cnt        = cnt + 1;
                next_ptr_c = PTR_W'((32'(idx) + 1) % NUM_FU);
            end
        end
    end

endmodule

// File: rtl/cdb_broadcast.sv
// Completion producer: buffers one finished result per functional unit and
// broadcasts up to N of them per cycle on the common data bus, chosen with
// rotating priority so no unit starves.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   squash        - mispredict flush, drops buffered and outgoing results
//   fu_valid/tag/rob_idx/value - per-FU finished result
//   fu_ready      - per-FU buffer can take a result at this edge
//   cdb_valid/tag/rob_idx/value - registered N-lane broadcast
module cdb_broadcast
    import cdb_broadcast_pkg::*;
#(
    parameter int unsigned N           = CDB_LANES,
    parameter int unsigned NUM_FU      = CDB_NUM_FU,
    parameter int unsigned PHYS_REG_SZ = PHYS_REG_SZ_R10K,
    parameter int unsigned TAG_BITS    = CDB_TAG_BITS,
    parameter int unsigned ROB_BITS    = ROB_IDX_BITS
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  squash,
    input  logic [NUM_FU-1:0]                     fu_valid,
    input  logic [NUM_FU-1:0][TAG_BITS-1:0]       fu_tag,
    input  logic [NUM_FU-1:0][ROB_BITS-1:0]       fu_rob_idx,
    input  logic [NUM_FU-1:0][CDB_DATA_BITS-1:0]  fu_value,
    output logic [NUM_FU-1:0]                     fu_ready,
    output logic [N-1:0]                          cdb_valid,
    output logic [N-1:0][TAG_BITS-1:0]            cdb_tag,
    output logic [N-1:0][ROB_BITS-1:0]            cdb_rob_idx,
    output logic [N-1:0][CDB_DATA_BITS-1:0]       cdb_value
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [TAG_BITS-1:0] SENTINEL = TAG_BITS'(PHYS_REG_SZ);
    localparam CDB_PACKET LANE_IDLE = '{valid: 1'b0, tag: SENTINEL, rob_idx: '0, value: '0};

    CDB_PACKET [NUM_FU-1:0] buf_q, buf_d;
    CDB_PACKET [N-1:0]      cdb_q, cdb_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [NUM_FU-1:0]        buf_valid;
    logic [NUM_FU-1:0]        grant;
    logic [N-1:0]             lane_valid;
    logic [N-1:0][NUM_FU-1:0] lane_src;
    logic [PTR_W-1:0]         next_ptr;

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            buf_valid[i] = buf_q[i].valid;
        end
    end

    rr_select #(
        .NUM_FU (NUM_FU),
        .N      (N)
    ) u_rr_select (
        .req_i        (buf_valid),
        .ptr_i        (rr_ptr_q),
        .grant_c      (grant),
        .lane_valid_c (lane_valid),
        .lane_src_c   (lane_src),
        .next_ptr_c   (next_ptr)
    );

    // A granted buffer drains this edge, so it can take a new result too.
    assign fu_ready = ~buf_valid | grant;

    // Next-state: lane loading, buffer drain/refill, pointer advance.
    always_comb begin
        buf_d    = buf_q;
        rr_ptr_d = rr_ptr_q;
        for (int unsigned j = 0; j < N; j++) begin
            cdb_d[j] = LANE_IDLE;
        end
        if (squash) begin
            // Offered results are dropped even where fu_ready is high.
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                buf_d[i].valid = 1'b0;
            end
            rr_ptr_d = '0;
        end else begin
            for (int unsigned j = 0; j < N; j++) begin
                for (int unsigned i = 0; i < NUM_FU; i++) begin
                    if (lane_valid[j] && lane_src[j][i]) begin
                        cdb_d[j] = buf_q[i];
                    end
                end
            end
            // Payload is written whenever the slot frees; valid decides use.
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fu_ready[i]) begin
                    buf_d[i].valid   = fu_valid[i];
                    buf_d[i].tag     = fu_tag[i];
                    buf_d[i].rob_idx = fu_rob_idx[i];
                    buf_d[i].value   = fu_value[i];
                end
            end
            rr_ptr_d = next_ptr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q    <= '0;
            rr_ptr_q <= '0;
            for (int unsigned j = 0; j < N; j++) begin
                cdb_q[j] <= LANE_IDLE;
            end
        end else begin
            buf_q    <= buf_d;
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
            cdb_valid[j]   = cdb_q[j].valid;
            cdb_tag[j]     = cdb_q[j].tag;
            cdb_rob_idx[j] = cdb_q[j].rob_idx;
            cdb_value[j]   = cdb_q[j].value;
        end
    end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Bench for cdb_broadcast: directed scenarios with literal expectations plus
// a randomized run, all compared every cycle against a behavioural model.
module tb_cdb_broadcast;
    import cdb_broadcast_pkg::*;

    localparam int unsigned NL = 2;
    localparam int unsigned NF = 4;
    localparam int unsigned TW = CDB_TAG_BITS;
    localparam int unsigned RW = ROB_IDX_BITS;
    localparam logic [TW-1:0] SENT = TW'(PHYS_REG_SZ_R10K);

    logic clock = 1'b0;
    logic reset;
    logic squash;
    logic [NF-1:0]          fu_valid;
    logic [NF-1:0][TW-1:0]  fu_tag;
    logic [NF-1:0][RW-1:0]  fu_rob_idx;
    logic [NF-1:0][31:0]    fu_value;
    logic [NF-1:0]          fu_ready;
    logic [NL-1:0]          cdb_valid;
    logic [NL-1:0][TW-1:0]  cdb_tag;
    logic [NL-1:0][RW-1:0]  cdb_rob_idx;
    logic [NL-1:0][31:0]    cdb_value;

    cdb_broadcast #(
        .N           (NL),
        .NUM_FU      (NF),
        .PHYS_REG_SZ (PHYS_REG_SZ_R10K),
        .TAG_BITS    (TW),
        .ROB_BITS    (RW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .fu_valid    (fu_valid),
        .fu_tag      (fu_tag),
        .fu_rob_idx  (fu_rob_idx),
        .fu_value    (fu_value),
        .fu_ready    (fu_ready),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_value   (cdb_value)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_v   [NF];
    logic [TW-1:0]   m_tag [NF];
    logic [RW-1:0]   m_rob [NF];
    logic [31:0]     m_val [NF];
    int              m_ptr = 0;
    bit              e_v   [NL];
    logic [TW-1:0]   e_tag [NL];
    logic [RW-1:0]   e_rob [NL];
    logic [31:0]     e_val [NL];
    bit              model_on = 1'b0;

    // j-th occupied buffer in wrapped order from m_ptr, or -1.
    function automatic int lane_src(input int j);
        int c;
        c = 0;
        for (int k = 0; k < NF; k++) begin
            int i;
            i = (m_ptr + k) % NF;
            if (m_v[i]) begin
                if (c == j) return i;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic logic [NF-1:0] exp_ready();
        logic [NF-1:0] r;
        for (int i = 0; i < NF; i++) r[i] = !m_v[i];
        for (int j = 0; j < NL; j++) begin
            int s;
            s = lane_src(j);
            if (s >= 0) r[s] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clock) begin : model_upd
        int src [NL];
        logic [NF-1:0] rdy;
        if (reset || squash) begin
            for (int i = 0; i < NF; i++) m_v[i] = 1'b0;
            m_ptr = 0;
            for (int j = 0; j < NL; j++) begin
                e_v[j] = 1'b0; e_tag[j] = SENT; e_rob[j] = '0; e_val[j] = '0;
            end
        end else begin
            rdy = exp_ready();
            for (int j = 0; j < NL; j++) src[j] = lane_src(j);
            for (int j = 0; j < NL; j++) begin
                if (src[j] >= 0) begin
                    e_v[j] = 1'b1; e_tag[j] = m_tag[src[j]];
                    e_rob[j] = m_rob[src[j]]; e_val[j] = m_val[src[j]];
                end else begin
                    e_v[j] = 1'b0; e_tag[j] = SENT; e_rob[j] = '0; e_val[j] = '0;
                end
            end
            for (int i = 0; i < NF; i++) begin
                if (rdy[i]) begin
                    m_v[i] = fu_valid[i];
                    m_tag[i] = fu_tag[i]; m_rob[i] = fu_rob_idx[i]; m_val[i] = fu_value[i];
                end
            end
            for (int j = 0; j < NL; j++) begin
                if (src[j] >= 0) m_ptr = (src[j] + 1) % NF;
            end
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            chk("fu_ready", 64'(fu_ready), 64'(exp_ready()));
            for (int j = 0; j < NL; j++) begin
                chk($sformatf("lane%0d", j),
                    64'({cdb_valid[j], cdb_tag[j], cdb_rob_idx[j], cdb_value[j]}),
                    64'({e_v[j], e_tag[j], e_rob[j], e_val[j]}));
            end
        end
    end

    // ---------------- functional-unit drivers ----------------
    bit            p_v   [NF];
    logic [TW-1:0] p_tag [NF];
    logic [RW-1:0] p_rob [NF];
    logic [31:0]   p_val [NF];
    logic [NF-1:0] acc;

    task automatic put(input int i, input int tag, input int rob, input logic [31:0] val);
        p_v[i] = 1'b1; p_tag[i] = TW'(tag); p_rob[i] = RW'(rob); p_val[i] = val;
    endtask

    // Drive pending results for one cycle, then advance to the next negedge.
    task automatic cyc();
        for (int i = 0; i < NF; i++) begin
            fu_valid[i] = p_v[i]; fu_tag[i] = p_tag[i];
            fu_rob_idx[i] = p_rob[i]; fu_value[i] = p_val[i];
        end
        acc = fu_valid & exp_ready();
        @(negedge clock);
        for (int i = 0; i < NF; i++) if (acc[i] || reset) p_v[i] = 1'b0;
        squash = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int first;
        int seen;
        int t;
        reset = 1'b1; squash = 1'b0; acc = '0;
        for (int i = 0; i < NF; i++) begin
            p_v[i] = 1'b0; p_tag[i] = '0; p_rob[i] = '0; p_val[i] = '0;
        end
        cyc();
        reset = 1'b1;
        cyc();
        model_on = 1'b1;

        // reset then idle
        repeat (3) cyc();
        chk("rst_valid", 64'(cdb_valid), 64'h0);
        chk("rst_tag0", 64'(cdb_tag[0]), 64'(SENT));
        chk("rst_tag1", 64'(cdb_tag[1]), 64'(SENT));
        chk("rst_ready", 64'(fu_ready), 64'hF);

        // single result from FU1
        put(1, 5, 3, 32'hDEAD);
        cyc(); cyc();
        chk("single_valid", 64'(cdb_valid), 64'b01);
        chk("single_tag", 64'(cdb_tag[0]), 64'd5);
        chk("single_rob", 64'(cdb_rob_idx[0]), 64'd3);
        chk("single_val", 64'(cdb_value[0]), 64'hDEAD);
        chk("single_l1tag", 64'(cdb_tag[1]), 64'(SENT));

        // all four with the pointer left at 2 by the previous grant
        for (int i = 0; i < NF; i++) put(i, 10 + i, i, 32'(100 + i));
        cyc();
        chk("ptr2_ready", 64'(fu_ready), 64'b1100);
        cyc();
        chk("ptr2_valid_a", 64'(cdb_valid), 64'b11);
        chk("ptr2_tag_a0", 64'(cdb_tag[0]), 64'd12);
        chk("ptr2_tag_a1", 64'(cdb_tag[1]), 64'd13);
        cyc();
        chk("ptr2_tag_b0", 64'(cdb_tag[0]), 64'd10);
        chk("ptr2_tag_b1", 64'(cdb_tag[1]), 64'd11);
        cyc();
        chk("ptr2_drained", 64'(cdb_valid), 64'b00);

        // all four from pointer 0, refill FU0, then squash
        squash = 1'b1; cyc();
        for (int i = 0; i < NF; i++) put(i, 20 + i, i, 32'(200 + i));
        cyc();
        chk("all4_ready", 64'(fu_ready), 64'b0011);
        put(0, 24, 4, 32'd204);
        cyc();
        chk("all4_valid", 64'(cdb_valid), 64'b11);
        chk("all4_tag0", 64'(cdb_tag[0]), 64'd20);
        chk("all4_tag1", 64'(cdb_tag[1]), 64'd21);
        chk("pre_sq_ready", 64'(fu_ready), 64'b1110);
        squash = 1'b1;
        put(1, 25, 5, 32'd205);
        cyc();
        chk("sq_valid", 64'(cdb_valid), 64'b00);
        chk("sq_ready", 64'(fu_ready), 64'hF);
        chk("sq_tag0", 64'(cdb_tag[0]), 64'(SENT));
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("sq_quiet%0d", k), 64'(cdb_valid), 64'b00);
        end

        // drain and refill on FU2
        put(2, 6, 6, 32'h66);
        cyc();
        put(2, 7, 7, 32'h77);
        cyc();
        chk("dr_old_valid", 64'(cdb_valid), 64'b01);
        chk("dr_old_tag", 64'(cdb_tag[0]), 64'd6);
        cyc();
        chk("dr_new_valid", 64'(cdb_valid), 64'b01);
        chk("dr_new_tag", 64'(cdb_tag[0]), 64'd7);
        chk("dr_new_val", 64'(cdb_value[0]), 64'h77);

        // sentinel-tag result is still broadcast
        put(0, int'(PHYS_REG_SZ_R10K), 9, 32'h1234);
        cyc(); cyc();
        chk("sent_valid", 64'(cdb_valid), 64'b01);
        chk("sent_tag", 64'(cdb_tag[0]), 64'(SENT));
        chk("sent_rob", 64'(cdb_rob_idx[0]), 64'd9);

        // FU0..2 under constant pressure, FU3 offers one result (tag 50)
        squash = 1'b1; cyc();
        for (int i = 0; i < 3; i++) put(i, 40 + i, i, 32'(400 + i));
        put(3, 50, 3, 32'd500);
        cyc();
        first = -1; seen = 0; t = 0;
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < NL; j++) begin
                if (cdb_valid[j] && cdb_tag[j] == 7'd50) begin
                    seen++;
                    if (first < 0) first = k;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!p_v[i]) begin
                    put(i, 51 + (t % 13), t % 32, 32'(t));
                    t++;
                end
            end
            cyc();
        end
        chk("starve_count", 64'(seen), 64'd1);
        chk("starve_cycle", 64'(first), 64'd3);

        // randomized traffic, squash and reset
        squash = 1'b1; cyc();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NF; i++) begin
                if (!p_v[i] && $urandom_range(0, 99) < 60) begin
                    int tg;
                    tg = ($urandom_range(0, 15) == 0) ? int'(PHYS_REG_SZ_R10K)
                                                      : int'($urandom_range(0, 63));
                    put(i, tg, int'($urandom_range(0, 31)), $urandom);
                end
            end
            if ($urandom_range(0, 49) == 0) squash = 1'b1;
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
